// File: rtl/out_port_fifo.sv
// ---------------------------------------------------------------------------
// out_port_fifo
//   Display output port. A small FIFO buffers ALU results that are pushed
//   with a display strobe. The head word is popped into a registered
//   parallel output and, when the serial engine is built in, also shifted
//   out MSB first as a DATA_W-bit frame.
//
//   Build option: define OUT_PORT_SERIAL_EN to include the IDLE/SHIFT serial
//   engine. Without it, one word pops into `out` on every cycle that the
//   FIFO is non-empty, and the serial outputs are tied low.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   display      : push strobe, samples data_in on the same edge
//   data_in      : word to display
//   ovf_clr      : clears the sticky overflow flag (a same-edge drop wins)
//   out          : registered parallel display value, changes only on a pop
//   serial_out   : serial data, MSB first, 0 while idle
//   serial_start : high during the first bit cycle of each frame
//   busy         : serial engine is shifting
//   full, empty  : FIFO status
//   count        : FIFO occupancy, 0..DEPTH
//   overflow     : sticky, set when a push was dropped
// ---------------------------------------------------------------------------
module out_port_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4   // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     display,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     ovf_clr,
  output logic [DATA_W-1:0]        out,
  output logic                     serial_out,
  output logic                     serial_start,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] out_q;
  logic              push, pop, drop;

  // Status comes from the registered count only, so a word written on this
  // edge is never visible to the pop decision of the same edge.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign overflow = overflow_q;
  assign out   = out_q;

  // Full is judged before any same-edge pop: a push into a full FIFO is
  // dropped even when a pop frees a slot on that edge.
  assign push = display & ~full;
  assign drop = display & full;

  always_comb begin
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  // Storage is not reset; stale contents are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      out_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;  // power-of-two depth wraps
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        out_q    <= mem_q[rd_ptr_q];
      end
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef OUT_PORT_SERIAL_EN
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W-1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: one IDLE cycle (the pop) between frames, then DATA_W
  // SHIFT cycles counted down to zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty)          state_d = SHIFT;
      SHIFT:   if (bitcnt_q == '0)  state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    pop          = (state_q == IDLE) & ~empty;
    busy         = (state_q == SHIFT);
    serial_out   = busy & shreg_q[DATA_W-1];
    serial_start = busy & (bitcnt_q == LAST_BIT);
  end

  // Shift datapath
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (pop) begin
      shreg_d  = mem_q[rd_ptr_q];
      bitcnt_d = LAST_BIT;
    end else if (state_q == SHIFT) begin
      shreg_d = shreg_q << 1;
      if (bitcnt_q != '0) bitcnt_d = bitcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end
`else
  // No serial engine: drain one word per cycle into the parallel output.
  assign pop          = ~empty;
  assign serial_out   = 1'b0;
  assign serial_start = 1'b0;
  assign busy         = 1'b0;
`endif

endmodule

// File: doc/out_port_fifo.md
OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 Parameter DATA_W, default 8: width of display words, out register and serial frame.
REQ-002 Parameter DEPTH, default 4: FIFO entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 display  input  1  push strobe; samples data_in on the same edge.
REQ-006 data_in  input  DATA_W  word to display (ALU result).
REQ-007 ovf_clr  input  1  clears sticky overflow flag.
REQ-008 out  output  DATA_W  registered parallel display value.
REQ-009 serial_out  output  1  serial data, MSB first.
REQ-010 serial_start  output  1  high only during the first bit cycle of a frame.
REQ-011 busy  output  1  serial engine in SHIFT state.
REQ-012 full, empty  output  1 each  FIFO status.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 overflow  output  1  sticky: a push was dropped.

Function
REQ-015 Push: display=1 and count<DEPTH on an edge SHALL write data_in at the write pointer; count increments the next cycle.
REQ-016 Push while full SHALL drop the word, set overflow, and leave FIFO contents and pointers unchanged.
REQ-017 Full is evaluated on count before any same-cycle pop; push when full with a simultaneous pop SHALL still be dropped.
REQ-018 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-019 A word pushed into an empty FIFO SHALL NOT be popped on the same edge; it is eligible on the following edge.
REQ-020 Serial FSM states: IDLE, SHIFT.
REQ-021 IDLE with empty=0: pop head, load out and shift register with it, bit counter = DATA_W-1, go to SHIFT.
REQ-022 SHIFT: serial_out = shift register MSB; shift left one bit per cycle; after DATA_W bit cycles return to IDLE.
REQ-023 serial_start SHALL be 1 exactly in the first SHIFT cycle of each frame; serial_out SHALL be 0 in IDLE.
REQ-024 Back-to-back frames SHALL be separated by exactly one IDLE cycle (frame period DATA_W+1 cycles).
REQ-025 Simultaneous push and pop (not full) SHALL leave count unchanged and preserve order.
REQ-026 ovf_clr SHALL clear overflow; if ovf_clr and a dropped push coincide, overflow SHALL be 1 (set wins).
REQ-027 out SHALL change only on a pop and hold otherwise.

Reset
REQ-028 rst_n=0 SHALL immediately force: out=0, serial_out=0, serial_start=0, busy=0, state IDLE, pointers 0, count=0, empty=1, full=0, overflow=0.
REQ-029 Reset mid-frame SHALL abort the frame; FIFO contents are discarded.
REQ-030 First push is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro OUT_PORT_SERIAL_EN defined: serial FSM per REQ-020..REQ-024.
REQ-032 OUT_PORT_SERIAL_EN undefined: no serial engine; whenever empty=0 one word pops into out every cycle; serial_out, serial_start, busy tied 0; FIFO and overflow behaviour unchanged.

Verification
REQ-033 DATA_W=8, serial on: push 0xA5 once -> after 1 cycle frame starts, serial_start high one cycle, serial_out 1,0,1,0,0,1,0,1, out=0xA5.
REQ-034 Push 0x11,0x22,0x33 on consecutive edges -> frames in order, 9-cycle period, count peaks 2, empty after last pop.
REQ-035 DEPTH=4, frame in progress, push 6 words back-to-back -> 4 stored after the in-flight word, 5th/6th dropped, overflow=1, ovf_clr -> overflow=0.
REQ-036 Full FIFO, push coincident with pop -> push dropped, count goes 4->3, overflow=1.
REQ-037 rst_n low at bit 3 of frame 0xFF -> serial_out=0, busy=0, count=0 immediately; no further frames.
REQ-038 Serial off: push 0x01,0x02 consecutive -> out=0x01 then 0x02 on successive cycles, serial_out stays 0.
